// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
//   Shared definitions for the RV64 pipeline hazard/stall controller.
//   - state_t   : cache-miss sequencing FSM states (RUN, IMISS, DMISS)
//   - RES_*     : execute-stage result_src encodings (RES_LOAD marks a load)
//   - FWD_*     : ALU operand forwarding select encodings
// -----------------------------------------------------------------------------
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_IMISS = 2'b01,
    ST_DMISS = 2'b10
  } state_t;

  // Result-source encodings seen on the execute-stage result_src bus.
  localparam logic [2:0] RES_ALU  = 3'b000;
  localparam logic [2:0] RES_LOAD = 3'b001;
  localparam logic [2:0] RES_PC4  = 3'b010;
  localparam logic [2:0] RES_IMM  = 3'b011;
  localparam logic [2:0] RES_CSR  = 3'b100;

  // Forwarding select encodings for the execute ALU operand muxes.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // True when a destination register write can hazard against a source:
  // the write is enabled, it does not target x0, and the addresses match.
  function automatic logic reg_hit(input logic       we,
                                   input logic [7:0] rd,
                                   input logic [7:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_forward_sel.sv
// -----------------------------------------------------------------------------
// forward_sel
//   Operand forwarding select for one execute-stage source register.
//   The memory stage holds the younger result, so it wins over writeback.
//
//   Ports:
//     i_rs_addr_e  execute-stage source register address
//     i_rd_addr_m  memory-stage destination address
//     i_reg_we_m   memory-stage register write enable
//     i_rd_addr_w  writeback-stage destination address
//     i_reg_we_w   writeback-stage register write enable
//     o_sel        FWD_MEM / FWD_WB / FWD_RF
// -----------------------------------------------------------------------------
module forward_sel
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] i_rs_addr_e,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_m,
  input  logic                  i_reg_we_m,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_w,
  input  logic                  i_reg_we_w,
  output logic [1:0]            o_sel
);

  logic hit_m;
  logic hit_w;

  // Addresses are zero-extended to the helper's fixed width.
  assign hit_m = reg_hit(i_reg_we_m, 8'(i_rd_addr_m), 8'(i_rs_addr_e));
  assign hit_w = reg_hit(i_reg_we_w, 8'(i_rd_addr_w), 8'(i_rs_addr_e));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    o_sel = FWD_RF;
    if (hit_m) begin
      o_sel = FWD_MEM;
    end else if (hit_w) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//   Hazard and stall controller for the 5-stage RV64 core.
//   - Stall/flush enables for the F/D/E/M/W pipeline registers, derived
//     combinationally from load-use, branch and cache-miss conditions.
//   - ALU operand forwarding selects (two forward_sel instances).
//   - Small FSM tracking the I-cache / D-cache miss handshakes.
//   - Saturating counter of cycles in which fetch was stalled.
//
//   Ports:
//     i_clk, i_arst                  clock, asynchronous active-high reset
//     i_rs1_addr_d, i_rs2_addr_d     decode-stage sources
//     i_rs1_addr_e, i_rs2_addr_e     execute-stage sources
//     i_rd_addr_e, i_result_src_e    execute-stage destination / result select
//     i_rd_addr_m, i_reg_we_m        memory-stage destination / write enable
//     i_rd_addr_w, i_reg_we_w        writeback-stage destination / write enable
//     i_pc_src_e                     branch/jump taken in execute
//     i_imem_miss, i_imem_done       I-cache miss level / fill-complete pulse
//     i_dmem_miss, i_dmem_done       D-cache miss level / fill-complete pulse
//     o_stall_f..o_stall_w           hold the stage register
//     o_flush_d, o_flush_e           clear the stage register to a bubble
//     o_forward_a, o_forward_b       ALU operand forwarding selects
//     o_stall_cnt                    saturating stall-cycle counter
// -----------------------------------------------------------------------------
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr_d,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr_d,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr_e,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr_e,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_e,
  input  logic [2:0]            i_result_src_e,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_m,
  input  logic                  i_reg_we_m,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_w,
  input  logic                  i_reg_we_w,
  input  logic                  i_pc_src_e,
  input  logic                  i_imem_miss,
  input  logic                  i_imem_done,
  input  logic                  i_dmem_miss,
  input  logic                  i_dmem_done,
  output logic                  o_stall_f,
  output logic                  o_stall_d,
  output logic                  o_stall_e,
  output logic                  o_stall_m,
  output logic                  o_stall_w,
  output logic                  o_flush_d,
  output logic                  o_flush_e,
  output logic [1:0]            o_forward_a,
  output logic [1:0]            o_forward_b,
  output logic [CNT_W-1:0]      o_stall_cnt
);

  state_t           state_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic dstall;
  logic istall;
  logic lwstall;

  logic stall_f, stall_d, stall_e, stall_m, stall_w;
  logic flush_d, flush_e;
  logic [1:0] fwd_a, fwd_b;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  // A D-miss done pulse releases the pipeline in the same cycle, so the
  // stages advance on the edge that ends the miss.
  assign dstall = i_dmem_miss & ~i_dmem_done;
  assign istall = i_imem_miss & ~i_imem_done;

  // Load in execute whose destination is read by the instruction in decode.
  assign lwstall = (i_result_src_e == RES_LOAD) && (i_rd_addr_e != '0) &&
                   ((i_rd_addr_e == i_rs1_addr_d) || (i_rd_addr_e == i_rs2_addr_d));

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    stall_w = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (dstall) begin
      // Whole pipeline frozen; a flush now would destroy held state.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      stall_w = 1'b1;
    end else begin
      stall_f = lwstall | istall;
      // A taken branch kills the decode instruction, so holding it is moot.
      stall_d = lwstall & ~i_pc_src_e;
      flush_e = lwstall | i_pc_src_e;
      // During an I-miss decode gets bubbles, unless a load-use stall is
      // holding the decode instruction in place.
      flush_d = i_pc_src_e | (istall & ~lwstall);
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarding (evaluated even while frozen; harmless since stages hold)
  // ---------------------------------------------------------------------------
  forward_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .i_rs_addr_e (i_rs1_addr_e),
    .i_rd_addr_m (i_rd_addr_m),
    .i_reg_we_m  (i_reg_we_m),
    .i_rd_addr_w (i_rd_addr_w),
    .i_reg_we_w  (i_reg_we_w),
    .o_sel       (fwd_a)
  );

  forward_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .i_rs_addr_e (i_rs2_addr_e),
    .i_rd_addr_m (i_rd_addr_m),
    .i_reg_we_m  (i_reg_we_m),
    .i_rd_addr_w (i_rd_addr_w),
    .i_reg_we_w  (i_reg_we_w),
    .o_sel       (fwd_b)
  );

  // ---------------------------------------------------------------------------
  // Miss-sequencing FSM and stall counter
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          // D-miss has priority over a simultaneous I-miss.
          if (i_dmem_miss) begin
            state_q <= ST_DMISS;
          end else if (i_imem_miss) begin
            state_q <= ST_IMISS;
          end
        end
        ST_IMISS: begin
          // A taken branch here does not leave IMISS: the fetch unit owns
          // the redirect once the fill completes.
          if (i_dmem_miss) begin
            state_q <= ST_DMISS;
          end else if (i_imem_done) begin
            state_q <= ST_RUN;
          end
        end
        ST_DMISS: begin
          if (i_dmem_done) begin
            state_q <= i_imem_miss ? ST_IMISS : ST_RUN;
          end
        end
        default: state_q <= ST_RUN;
      endcase

      if (stall_f && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all combinational outputs read as zero while reset is asserted.
  // ---------------------------------------------------------------------------
  always_comb begin
    o_stall_f   = stall_f & ~i_arst;
    o_stall_d   = stall_d & ~i_arst;
    o_stall_e   = stall_e & ~i_arst;
    o_stall_m   = stall_m & ~i_arst;
    o_stall_w   = stall_w & ~i_arst;
    o_flush_d   = flush_d & ~i_arst;
    o_flush_e   = flush_e & ~i_arst;
    o_forward_a = i_arst ? FWD_RF : fwd_a;
    o_forward_b = i_arst ? FWD_RF : fwd_b;
  end

  assign o_stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Hazard and stall controller for the 5-stage RV64 core. It drives the stall and flush enables of the fetch, decode, execute, memory and writeback pipeline registers, and the operand-forwarding selects for the execute ALU. A small FSM sequences the I-cache and D-cache miss handshakes. A saturating counter records stall cycles for performance monitoring.

Parameters:
REG_ADDR_W, 5, register-file address width
CNT_W, 32, stall-cycle counter width

Ports:
i_clk  in  1  clock
i_arst  in  1  reset
i_rs1_addr_d  in  REG_ADDR_W  decode-stage source 1
i_rs2_addr_d  in  REG_ADDR_W  decode-stage source 2
i_rs1_addr_e  in  REG_ADDR_W  execute-stage source 1
i_rs2_addr_e  in  REG_ADDR_W  execute-stage source 2
i_rd_addr_e  in  REG_ADDR_W  execute-stage destination
i_result_src_e  in  3  execute-stage result select
i_rd_addr_m  in  REG_ADDR_W  memory-stage destination
i_reg_we_m  in  1  memory-stage register write enable
i_rd_addr_w  in  REG_ADDR_W  writeback-stage destination
i_reg_we_w  in  1  writeback-stage register write enable
i_pc_src_e  in  1  branch/jump taken in execute
i_imem_miss  in  1  I-cache miss, level, held until fill
i_imem_done  in  1  I-cache fill complete, 1-cycle pulse
i_dmem_miss  in  1  D-cache miss, level
i_dmem_done  in  1  D-cache fill complete, 1-cycle pulse
o_stall_f, o_stall_d, o_stall_e, o_stall_m, o_stall_w  out  1 each  hold the stage register
o_flush_d, o_flush_e  out  1 each  clear the stage register to a bubble
o_forward_a, o_forward_b  out  2 each  00 register file, 10 from memory stage, 01 from writeback stage
o_stall_cnt  out  CNT_W  stall-cycle counter

Behaviour:
- Reset: asynchronous and active-high on i_arst. FSM goes to RUN and o_stall_cnt is cleared to 0. Because every other output is combinational, all of them are 0 during reset.
- FSM states are RUN, IMISS and DMISS. Transitions take effect at the next i_clk edge. Stall and flush outputs are combinational from the current state and the current inputs.
- RUN to DMISS when i_dmem_miss=1. D-miss has priority over I-miss.
- RUN to IMISS when i_imem_miss=1 and i_dmem_miss=0.
- IMISS to DMISS when i_dmem_miss=1.
- IMISS to RUN on i_imem_done.
- DMISS on i_dmem_done goes to IMISS if i_imem_miss=1, otherwise to RUN.
- dstall = i_dmem_miss and not i_dmem_done.
  - When dstall=1, all five stall outputs are 1 and both flushes are forced to 0.
  - In the i_dmem_done cycle, dstall=0, so the stages advance in that same cycle.
- istall = i_imem_miss and not i_imem_done.
- lwstall = (i_result_src_e == RES_LOAD) and (i_rd_addr_e != 0) and (i_rd_addr_e matches i_rs1_addr_d or i_rs2_addr_d).
- When dstall=0:
  - o_stall_f = lwstall or istall
  - o_stall_d = lwstall and not i_pc_src_e
  - o_flush_e = lwstall or i_pc_src_e
  - o_flush_d = i_pc_src_e or (istall and not lwstall)
  - o_stall_e, o_stall_m, o_stall_w = 0
- A taken branch during IMISS asserts the flushes. The FSM stays in IMISS; the fetch unit owns the redirect.
- Forward A selection (B is identical using rs2_e):
  - 10 if i_reg_we_m and i_rd_addr_m != 0 and i_rd_addr_m == i_rs1_addr_e. The memory stage wins over writeback.
  - otherwise 01 if the same condition holds for the writeback stage.
  - otherwise 00.
- Forward selects are computed even during dstall; this is harmless because the stages are frozen.
- o_stall_cnt increments by 1 on every clock edge where o_stall_f=1. It saturates at all-ones.
- i_dmem_done or i_imem_done arriving outside its matching wait state is ignored.
- Reset asserted mid-miss returns the FSM to RUN immediately.

Decomposition:
- Shared package pipeline_pkg holds:
  - the FSM state enum (RUN, IMISS, DMISS)
  - RES_LOAD = 3'b001 and the other result_src encodings
  - FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10
- One sub-module, forward_sel, is instantiated twice (once for operand A, once for operand B). It takes one execute-stage source address and returns a 2-bit select.

Test Plan:
- Load-use: E stage holds a load (result_src_e=001, rd_e=5) and D has rs1_d=5 -> stall_f=1, stall_d=1, flush_e=1 for one cycle, with counter +1. Repeating with rd_e=0 -> no stall.
- Forwarding: rd_m=7 with reg_we_m=1, rd_w=7 with reg_we_w=1, rs1_e=7, rs2_e=7 -> forward_a=10, forward_b=10. Dropping reg_we_m -> 01. Setting rd_m=rd_w=0 -> 00.
- Branch: pc_src_e=1 concurrent with lwstall -> flush_d=1, flush_e=1, stall_d=0.
- D-miss: dmem_miss held 4 cycles with done on the 4th -> all stalls 1 for 3 cycles, no flushes, counter +3. FSM is RUN after the pulse.
- Simultaneous misses: imem_miss and dmem_miss both rise -> DMISS first. After dmem_done -> IMISS with stall_f=1, flush_d=1, stall_e=0. After imem_done -> RUN.
- Reset during DMISS: assert i_arst -> all outputs 0, counter 0, FSM RUN. After release, a counter preset near all-ones saturates rather than wrapping.
